// File: rtl/fifo_if.sv
// Producer-side bundle for the fifo: write data, push request,
// registered read data and occupancy flags.
interface fifo_if #(
  parameter int SIZE = 8
);
  logic [SIZE-1:0] data_in;
  logic            valid_write;
  logic [SIZE-1:0] data_out;
  logic            f_flag;
  logic            e_flag;
  logic            almost_full_flag;
  logic            almost_empty_flag;

  modport master (
    output data_in,
    output valid_write,
    input  data_out,
    input  f_flag,
    input  e_flag,
    input  almost_full_flag,
    input  almost_empty_flag
  );

  modport slave (
    input  data_in,
    input  valid_write,
    output data_out,
    output f_flag,
    output e_flag,
    output almost_full_flag,
    output almost_empty_flag
  );
endinterface

// File: rtl/fifo.sv
// Single-clock FIFO: producer pushes every cycle, an internal divider
// pops one word every READ_DIV clocks while data is present.
module fifo #(
  parameter int SIZE     = 8,
  parameter int DEPTH    = 4,
  parameter int READ_DIV = 5,
  parameter int AF_LEVEL = 2**DEPTH-1,
  parameter int AE_LEVEL = 1
) (
  input  logic w_clk,
  input  logic n_rst,
  fifo_if.slave bus
);
  localparam int ENTRIES = 2**DEPTH;
  localparam int DW = (READ_DIV > 1) ? $clog2(READ_DIV) : 1;
  localparam logic [DW-1:0] L_DMAX = DW'(READ_DIV-1);
  localparam logic [DEPTH:0] L_FULL = ENTRIES[DEPTH:0];
  localparam logic [DEPTH:0] L_AF = AF_LEVEL[DEPTH:0];
  localparam logic [DEPTH:0] L_AE = AE_LEVEL[DEPTH:0];

  logic [SIZE-1:0]  r_mem [ENTRIES];
  logic [DEPTH-1:0] r_wptr;
  logic [DEPTH-1:0] r_rptr;
  logic [DEPTH:0]   r_count;
  logic [DW-1:0]    r_div;
  logic [SIZE-1:0]  r_dout;

  logic w_wr;
  logic w_rd;

  assign w_wr = bus.valid_write && (r_count != L_FULL) && !n_rst;
  assign w_rd = (r_div == L_DMAX) && (r_count != '0);

  // Storage is never reset; stale words are unreachable once pointers clear.
  always_ff @(posedge w_clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= bus.data_in;
    end
  end

  always_ff @(posedge w_clk) begin
    if (n_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_div   <= '0;
      r_dout  <= '0;
    end else begin
      r_div <= (r_div == L_DMAX) ? '0 : r_div + 1'b1;
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_rd) begin
        r_dout <= r_mem[r_rptr];
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign bus.data_out          = r_dout;
  assign bus.f_flag            = (r_count == L_FULL);
  assign bus.e_flag            = (r_count == '0);
  assign bus.almost_full_flag  = (r_count >= L_AF);
  assign bus.almost_empty_flag = (r_count <= L_AE);
endmodule

// File: tb/tb_fifo.sv
// Randomised and directed checks of fifo against a queue-based
// model that pops on every fifth non-reset clock.
module tb_fifo;
  localparam int ENT = 16;
  localparam int DIV = 5;

  logic clk;
  logic rst;
  fifo_if #(.SIZE(8)) bus ();

  fifo #(
    .SIZE(8), .DEPTH(4), .READ_DIV(DIV),
    .AF_LEVEL(15), .AE_LEVEL(1)
  ) dut (
    .w_clk(clk),
    .n_rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0] mq[$];
  logic [7:0] m_dout;
  int         m_e;
  bit         m_rd;
  int         m_acc;
  logic [7:0] dpops[$];

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick(input logic r, input logic vw,
                      input logic [31:0] d);
    bit rd, wr;
    int n;
    rst = r;
    bus.valid_write = vw;
    bus.data_in = d[7:0];
    @(posedge clk);
    m_rd = 0;
    if (r) begin
      mq.delete();
      m_dout = '0;
      m_e = 0;
    end else begin
      rd = (m_e % DIV == DIV-1) && (mq.size() > 0);
      wr = vw && (mq.size() < ENT);
      if (rd) begin
        m_dout = mq.pop_front();
        m_rd = 1;
      end
      if (wr) begin
        mq.push_back(d[7:0]);
        m_acc++;
      end
      m_e++;
    end
    #1;
    n = mq.size();
    if (m_rd) dpops.push_back(bus.data_out);
    check("data_out", {24'd0, bus.data_out}, {24'd0, m_dout});
    check("e_flag", {31'd0, bus.e_flag}, {31'd0, n == 0});
    check("f_flag", {31'd0, bus.f_flag}, {31'd0, n == ENT});
    check("af_flag", {31'd0, bus.almost_full_flag}, {31'd0, n >= 15});
    check("ae_flag", {31'd0, bus.almost_empty_flag}, {31'd0, n <= 1});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 0);
  endtask

  task automatic do_reset();
    tick(1'b1, 1'b1, 32'h55);
    tick(1'b1, 1'b1, 32'h66);
    dpops.delete();
    m_acc = 0;
  endtask

  initial begin
    int k;
    bit hit;
    logic [31:0] ord [4];
    rst = 1'b1;
    bus.valid_write = 1'b0;
    bus.data_in = '0;
    m_dout = '0;
    m_e = 0;
    m_acc = 0;

    // reset with push held high: nothing may be stored
    do_reset();
    check("rst_dout", {24'd0, bus.data_out}, 32'd0);
    check("rst_e", {31'd0, bus.e_flag}, 32'd1);
    idle(12);
    check("rst_nopop", dpops.size(), 32'd0);

    // ordered transfer with truncation
    do_reset();
    ord[0] = 21; ord[1] = 503; ord[2] = 90; ord[3] = 10;
    for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, ord[i]);
    idle(25);
    check("ord_n", dpops.size(), 32'd4);
    if (dpops.size() == 4) begin
      check("ord0", {24'd0, dpops[0]}, 32'd21);
      check("ord1", {24'd0, dpops[1]}, 32'd247);
      check("ord2", {24'd0, dpops[2]}, 32'd90);
      check("ord3", {24'd0, dpops[3]}, 32'd10);
    end
    check("ord_e", {31'd0, bus.e_flag}, 32'd1);

    // fill and overflow: word 19 meets a full fifo
    do_reset();
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, i);
    idle(120);
    check("fill_n", dpops.size(), 32'd19);
    check("fill_acc", dpops.size(), m_acc);
    for (int i = 1; i < dpops.size(); i++)
      check("fill_inc", {31'd0, dpops[i] > dpops[i-1]}, 32'd1);
    for (int i = 0; i < dpops.size(); i++)
      check("fill_val", {24'd0, dpops[i]}, i);

    // wrap-around stream, one write just after each read slot
    do_reset();
    for (int i = 0; i < 40; i++) begin
      tick(1'b0, 1'b1, i);
      idle(4);
    end
    check("wrap_n", dpops.size(), 32'd40);
    for (int i = 0; i < dpops.size(); i++)
      check("wrap_val", {24'd0, dpops[i]}, i);

    // full with simultaneous read slot
    do_reset();
    k = 0;
    while (mq.size() < ENT && k < 100) begin
      tick(1'b0, 1'b1, k);
      k++;
    end
    check("full_reach", {31'd0, bus.f_flag}, 32'd1);
    hit = 0;
    for (int i = 0; i < 10 && !hit; i++) begin
      tick(1'b0, 1'b1, 32'hEE);
      if (m_rd) begin
        hit = 1;
        check("fullrd_f", {31'd0, bus.f_flag}, 32'd0);
        check("fullrd_af", {31'd0, bus.almost_full_flag}, 32'd1);
      end
    end
    check("fullrd_hit", {31'd0, hit}, 32'd1);

    // reset mid-operation with stale entries
    do_reset();
    k = 0;
    while (mq.size() < 7 && k < 50) begin
      tick(1'b0, 1'b1, 32'h30 + k);
      k++;
    end
    tick(1'b1, 1'b0, 0);
    check("mid_e", {31'd0, bus.e_flag}, 32'd1);
    check("mid_ae", {31'd0, bus.almost_empty_flag}, 32'd1);
    dpops.delete();
    tick(1'b0, 1'b1, 32'hAA);
    k = 0;
    while (dpops.size() == 0 && k < 10) begin
      idle(1);
      k++;
    end
    check("mid_pop", dpops.size(), 32'd1);
    if (dpops.size() > 0) check("mid_aa", {24'd0, dpops[0]}, 32'hAA);
    idle(30);
    check("mid_stale", dpops.size(), 32'd1);

    // randomised traffic with occasional reset
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 199) == 0,
           $urandom_range(0, 9) < 4,
           $urandom);
    end
    idle(100);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
